// File: rtl/sisr_signature_checker_if.sv
// ============================================================================
// sisr_signature_checker_if : monitor/scan-chain to SISR checker bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface sisr_signature_checker_if #(
  parameter int WIDTH = 16
);
  logic             SISR_En;
  logic             scanOut;
  logic             done;
  logic [WIDTH-1:0] signature;
  logic [15:0]      bitCount;
  logic             checkValid;
  logic             pass;
  logic             fail;

  modport master (
    output SISR_En, scanOut, done,
    input  signature, bitCount, checkValid, pass, fail
  );

  modport slave (
    input  SISR_En, scanOut, done,
    output signature, bitCount, checkValid, pass, fail
  );
endinterface

`default_nettype wire

// File: rtl/sisr_signature_checker.sv
// ============================================================================
// sisr_signature_checker : SISR response compactor with golden-value check
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sisr_signature_checker #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter logic [WIDTH-1:0] GOLDEN   = '0,
  parameter logic [15:0]      EXP_BITS = 16'd0
) (
  input  logic                   clk,
  input  logic                   rstIn,
  sisr_signature_checker_if.slave bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sig;
  logic [15:0]      r_count;
  logic             r_valid;
  logic             r_pass;
  logic             r_fail;

  logic             w_fb;
  logic [WIDTH-1:0] w_next_sig;
  logic [15:0]      w_next_count;
  logic             w_compress;
  logic             w_match;

  assign w_fb         = bus.scanOut ^ (^(r_sig & POLY));
  assign w_next_sig   = {r_sig[WIDTH-2:0], w_fb};
  assign w_next_count = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
  assign w_compress   = (r_state == ST_RUN) && bus.SISR_En;
  // Count check is skipped entirely when no expected count is configured
  assign w_match      = (r_sig == GOLDEN) &&
                        ((EXP_BITS == 16'd0) || (r_count == EXP_BITS));

  always_ff @(posedge clk) begin
    if (rstIn) begin
      r_state <= ST_RUN;
      r_sig   <= SEED;
      r_count <= 16'd0;
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_compress) begin
            r_sig   <= w_next_sig;
            r_count <= w_next_count;
          end
          if (bus.done) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_state <= ST_RESULT;
          r_valid <= 1'b1;
          r_pass  <= w_match;
          r_fail  <= !w_match;
        end
        ST_RESULT: begin
          r_state <= ST_RESULT;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.signature  = r_sig;
  assign bus.bitCount   = r_count;
  assign bus.checkValid = r_valid;
  assign bus.pass       = r_pass;
  assign bus.fail       = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_sisr_signature_checker.sv
// Three checkers with different golden settings share one stimulus stream and
// are compared each cycle against a behavioural model of the compression law.
`default_nettype none

module tb_sisr_signature_checker;

  localparam logic [15:0] POLY_T = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] p);
    return {p[0] ^ p[2] ^ p[3] ^ p[5], p[15:1]};
  endfunction

  function automatic logic [15:0] sisr_step(input logic [15:0] s, input logic b);
    return {s[14:0], b ^ (^(s & POLY_T))};
  endfunction

  function automatic logic [15:0] lfsr_sig(input int n);
    logic [15:0] p;
    logic [15:0] s;
    p = 16'hACE1;
    s = 16'h0000;
    for (int i = 0; i < n; i++) begin
      s = sisr_step(s, p[0]);
      p = lfsr_next(p);
    end
    return s;
  endfunction

  localparam logic [15:0] G1 = lfsr_sig(200) ^ 16'h0001;

  function automatic logic [15:0] gold(input int k);
    return (k == 1) ? G1 : 16'h0000;
  endfunction

  function automatic logic [15:0] expb(input int k);
    return (k == 2) ? 16'd50 : 16'd0;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic sc  = 1'b0;
  logic dn  = 1'b0;
  bit   armed = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sisr_signature_checker_if #(.WIDTH(16)) if0 ();
  sisr_signature_checker_if #(.WIDTH(16)) if1 ();
  sisr_signature_checker_if #(.WIDTH(16)) if2 ();

  assign if0.SISR_En = en;
  assign if0.scanOut = sc;
  assign if0.done    = dn;
  assign if1.SISR_En = en;
  assign if1.scanOut = sc;
  assign if1.done    = dn;
  assign if2.SISR_En = en;
  assign if2.scanOut = sc;
  assign if2.done    = dn;

  sisr_signature_checker #(.WIDTH(16), .POLY(POLY_T), .SEED(16'h0),
    .GOLDEN(16'h0), .EXP_BITS(16'd0)) dut0 (.clk(clk), .rstIn(rst), .bus(if0.slave));
  sisr_signature_checker #(.WIDTH(16), .POLY(POLY_T), .SEED(16'h0),
    .GOLDEN(G1), .EXP_BITS(16'd0)) dut1 (.clk(clk), .rstIn(rst), .bus(if1.slave));
  sisr_signature_checker #(.WIDTH(16), .POLY(POLY_T), .SEED(16'h0),
    .GOLDEN(16'h0), .EXP_BITS(16'd50)) dut2 (.clk(clk), .rstIn(rst), .bus(if2.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: compressed stream, bit total, and verdict one cycle after done
  logic [15:0] m_sig = 16'h0;
  logic [15:0] m_cnt = 16'h0;
  bit          m_pending = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_pass [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    if (rst) begin
      m_sig = 16'h0; m_cnt = 16'h0; m_pending = 1'b0; m_valid = 1'b0;
      for (int k = 0; k < 3; k++) m_pass[k] = 1'b0;
    end else if (m_valid) begin
      m_valid = 1'b1;
    end else if (m_pending) begin
      m_pending = 1'b0;
      m_valid   = 1'b1;
      for (int k = 0; k < 3; k++)
        m_pass[k] = (m_sig == gold(k)) && ((expb(k) == 16'd0) || (m_cnt == expb(k)));
    end else begin
      if (en) begin
        m_sig = sisr_step(m_sig, sc);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (dn) m_pending = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("sig0",   32'(if0.signature),  32'(m_sig));
      chk("sig1",   32'(if1.signature),  32'(m_sig));
      chk("sig2",   32'(if2.signature),  32'(m_sig));
      chk("cnt0",   32'(if0.bitCount),   32'(m_cnt));
      chk("cnt2",   32'(if2.bitCount),   32'(m_cnt));
      chk("valid0", 32'(if0.checkValid), 32'(m_valid));
      chk("valid1", 32'(if1.checkValid), 32'(m_valid));
      chk("valid2", 32'(if2.checkValid), 32'(m_valid));
      chk("pass0",  32'(if0.pass),       32'(m_valid && m_pass[0]));
      chk("fail0",  32'(if0.fail),       32'(m_valid && !m_pass[0]));
      chk("pass1",  32'(if1.pass),       32'(m_valid && m_pass[1]));
      chk("fail1",  32'(if1.fail),       32'(m_valid && !m_pass[1]));
      chk("pass2",  32'(if2.pass),       32'(m_valid && m_pass[2]));
      chk("fail2",  32'(if2.fail),       32'(m_valid && !m_pass[2]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; dn = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    en = 1'b1; sc = b; dn = 1'b0;
    tick();
    en = 1'b0;
  endtask

  task automatic finish_test();
    dn = 1'b1; en = 1'b0;
    tick();
    chk("valid_in_check", 32'(if0.checkValid), 32'd0);
    dn = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    tick();
    tick();
    rst = 1'b0;
    armed = 1'b1;
    chk("reset_sig", 32'(if0.signature), 32'h0);
    chk("reset_cnt", 32'(if0.bitCount), 32'h0);
    chk("reset_flags", 32'({if0.checkValid, if0.pass, if0.fail}), 32'h0);

    // Zero stream
    repeat (100) bit_in(1'b0);
    chk("zero_sig", 32'(if0.signature), 32'h0);
    chk("zero_cnt", 32'(if0.bitCount), 32'd100);
    finish_test();
    chk("zero_pass", 32'({if0.checkValid, if0.pass, if0.fail}), 32'b110);
    chk("zero_cnt_fail", 32'(if2.fail), 32'd1);
    do_reset();

    // Single-bit walk up to the first tap at bit 10
    bit_in(1'b1);
    chk("walk_1", 32'(if0.signature), 32'h0001);
    bit_in(1'b0);
    chk("walk_2", 32'(if0.signature), 32'h0002);
    repeat (9) bit_in(1'b0);
    chk("walk_tap", 32'(if0.signature), 32'h0400);
    bit_in(1'b0);
    chk("walk_fb", 32'(if0.signature), 32'h0801);
    repeat (16) bit_in(1'b0);
    do_reset();

    // Count check: signature stays zero, only the bit total differs
    repeat (49) bit_in(1'b0);
    finish_test();
    chk("cnt49_fail", 32'({if2.pass, if2.fail}), 32'b01);
    do_reset();
    repeat (50) bit_in(1'b0);
    finish_test();
    chk("cnt50_pass", 32'({if2.pass, if2.fail}), 32'b10);
    do_reset();

    // Final bit on the done edge
    repeat (5) bit_in(1'b0);
    en = 1'b1; sc = 1'b1; dn = 1'b1;
    tick();
    en = 1'b0; dn = 1'b0;
    chk("simul_sig", 32'(if0.signature), 32'h0001);
    chk("simul_cnt", 32'(if0.bitCount), 32'd6);
    tick();
    chk("simul_fail", 32'({if0.checkValid, if0.pass, if0.fail}), 32'b101);
    do_reset();

    // Mismatch against golden off by one bit, then frozen outputs
    p = 16'hACE1;
    repeat (200) begin
      bit_in(p[0]);
      p = lfsr_next(p);
    end
    finish_test();
    chk("mis_flags", 32'({if1.checkValid, if1.pass, if1.fail}), 32'b101);
    chk("mis_sig", 32'(if1.signature), 32'(G1 ^ 16'h0001));
    repeat (20) begin
      en = 1'($urandom); sc = 1'($urandom); dn = 1'($urandom);
      tick();
    end
    en = 1'b0; dn = 1'b0;
    chk("mis_frozen", 32'(if1.fail), 32'd1);
    do_reset();

    // Reset mid-stream and from RESULT
    repeat (30) bit_in(1'($urandom));
    rst = 1'b1; en = 1'b1; sc = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    chk("midrst_sig", 32'(if0.signature), 32'h0);
    chk("midrst_cnt", 32'(if0.bitCount), 32'h0);
    bit_in(1'b1);
    chk("midrst_resume", 32'(if0.signature), 32'h0001);
    repeat (20) bit_in(1'($urandom));
    finish_test();
    rst = 1'b1; dn = 1'b1;
    tick();
    rst = 1'b0; dn = 1'b0;
    chk("resrst_flags", 32'({if0.checkValid, if0.pass, if0.fail}), 32'h0);
    chk("resrst_cnt", 32'(if0.bitCount), 32'h0);

    // Randomized traffic with sporadic done and reset
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 9) < 7);
      sc  = 1'($urandom);
      dn  = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b0; dn = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
